// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if
//   Bundles the pixel strobe and every decoded timing output of the
//   VGA timing generator.
//   Parameters: X_W / Y_W set the width of the scaled coordinates.
//   Signals:
//     i_pix_stb     pixel strobe into the generator
//     o_hs, o_vs    horizontal / vertical sync at their configured polarity
//     o_active      current pixel is inside the drawable window
//     o_blanking    current pixel is outside the visible area
//     o_line_start  first pixel of a line
//     o_animate     last pixel of the last window line (one strobe per frame)
//     o_screenend   last pixel of the frame (one strobe per frame)
//     o_x, o_y      scaled pixel coordinates
//     o_frame       8-bit frame counter
//   Modports: master = generator side, slave = consumer side.
interface vga_timing_gen_if #(
    parameter int X_W = 10,
    parameter int Y_W = 9
);
    logic           i_pix_stb;
    logic           o_hs;
    logic           o_vs;
    logic           o_active;
    logic           o_blanking;
    logic           o_line_start;
    logic           o_animate;
    logic           o_screenend;
    logic [X_W-1:0] o_x;
    logic [Y_W-1:0] o_y;
    logic [7:0]     o_frame;

    modport master (
        input  i_pix_stb,
        output o_hs, o_vs, o_active, o_blanking, o_line_start,
        output o_animate, o_screenend, o_x, o_y, o_frame
    );

    modport slave (
        output i_pix_stb,
        input  o_hs, o_vs, o_active, o_blanking, o_line_start,
        input  o_animate, o_screenend, o_x, o_y, o_frame
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Free-running VGA raster counters with decoded sync, blanking, window
//   and scaled-coordinate outputs. The counters advance once per pixel
//   strobe; every output is a pure decode of the registered counters, so
//   outputs change only on strobed edges.
//   Ports:
//     i_clk  base clock (rising edge)
//     i_rst  synchronous active-high reset
//     bus    vga_timing_gen_if master modport (strobe in, timing outputs)
module vga_timing_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int SCALE_SHIFT = 1,
    parameter int WIN_STA     = 60,
    parameter int WIN_END     = 420,
    parameter int X_W         = 10,
    parameter int Y_W         = 9
) (
    input logic               i_clk,
    input logic               i_rst,
    vga_timing_gen_if.master  bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HC_W    = $clog2(H_TOTAL);
    localparam int VC_W    = $clog2(V_TOTAL);

    // Decode thresholds pre-sized to the counter widths.
    localparam logic [HC_W-1:0] H_LAST   = HC_W'(H_TOTAL - 1);
    localparam logic [HC_W-1:0] H_ACT    = HC_W'(H_ACTIVE);
    localparam logic [HC_W-1:0] HS_STA   = HC_W'(H_ACTIVE + H_FP);
    localparam logic [HC_W-1:0] HS_END   = HC_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VC_W-1:0] V_LAST   = VC_W'(V_TOTAL - 1);
    localparam logic [VC_W-1:0] V_ACT    = VC_W'(V_ACTIVE);
    localparam logic [VC_W-1:0] VS_STA   = VC_W'(V_ACTIVE + V_FP);
    localparam logic [VC_W-1:0] VS_END   = VC_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VC_W-1:0] WIN_S    = VC_W'(WIN_STA);
    localparam logic [VC_W-1:0] WIN_E    = VC_W'(WIN_END);
    localparam logic [VC_W-1:0] WIN_LAST = VC_W'(WIN_END - 1);
    // Below the window o_y freezes on the last window row's coordinate.
    localparam logic [Y_W-1:0]  Y_CLAMP  = Y_W'((WIN_END - WIN_STA - 1) >> SCALE_SHIFT);

    if (WIN_END > V_ACTIVE || WIN_STA >= WIN_END || SCALE_SHIFT < 0 || SCALE_SHIFT > 3) begin : g_bad_param
        $error("vga_timing_gen: illegal WIN_STA/WIN_END/SCALE_SHIFT combination");
    end

    logic [HC_W-1:0] h_count;
    logic [VC_W-1:0] v_count;
    logic [7:0]      frame_q;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            h_count <= '0;
            v_count <= '0;
            frame_q <= '0;
        end else if (bus.i_pix_stb) begin
            if (h_count == H_LAST) begin
                h_count <= '0;
                if (v_count == V_LAST) begin
                    v_count <= '0;
                    frame_q <= frame_q + 8'd1;
                end else begin
                    v_count <= v_count + 1'b1;
                end
            end else begin
                h_count <= h_count + 1'b1;
            end
        end
    end

    logic           hs_on;
    logic           vs_on;
    logic [X_W-1:0] x_c;
    logic [Y_W-1:0] y_c;

    // NOTE: every signal gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        hs_on = 1'b0;
        vs_on = 1'b0;
        x_c   = '0;
        y_c   = '0;

        hs_on = (h_count >= HS_STA) && (h_count < HS_END);
        vs_on = (v_count >= VS_STA) && (v_count < VS_END);

        if (h_count < H_ACT) begin
            x_c = X_W'(h_count >> SCALE_SHIFT);
        end

        if (v_count >= WIN_E) begin
            y_c = Y_CLAMP;
        end else if (v_count >= WIN_S) begin
            y_c = Y_W'((v_count - WIN_S) >> SCALE_SHIFT);
        end
    end

    assign bus.o_hs         = hs_on ? HS_POL : ~HS_POL;
    assign bus.o_vs         = vs_on ? VS_POL : ~VS_POL;
    assign bus.o_blanking   = (h_count >= H_ACT) || (v_count >= V_ACT);
    assign bus.o_active     = (h_count < H_ACT) && (v_count >= WIN_S) && (v_count < WIN_E);
    assign bus.o_line_start = (h_count == '0);
    assign bus.o_animate    = (v_count == WIN_LAST) && (h_count == H_LAST);
    assign bus.o_screenend  = (v_count == V_LAST) && (h_count == H_LAST);
    assign bus.o_x          = x_c;
    assign bus.o_y          = y_c;
    assign bus.o_frame      = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Two generators share clock, reset and strobe: dut_a with default timing,
//   dut_b with inverted sync polarity, no scaling and a short 13-line frame
//   so whole frames fit in a short run. A behavioural raster model predicts
//   each DUT's outputs per edge; predictions are queued when stimulus is
//   driven and popped and compared on the following falling edge.
module tb_vga_timing_gen;

    typedef struct {
        int ha, hf, hsw, hb;
        int va, vf, vsw, vb;
        int ws, we, sh;
        bit hp, vp;
    } cfg_t;

    typedef struct {
        int h, v, frame;
    } pos_t;

    typedef struct packed {
        logic        hs, vs, active, blanking, line_start, animate, screenend;
        logic [31:0] x, y, frame;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic stb;
    always #5 clk = ~clk;

    vga_timing_gen_if #(.X_W(10), .Y_W(9)) bus_a ();
    vga_timing_gen_if #(.X_W(10), .Y_W(9)) bus_b ();
    assign bus_a.i_pix_stb = stb;
    assign bus_b.i_pix_stb = stb;

    vga_timing_gen u_dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_a)
    );

    vga_timing_gen #(
        .V_ACTIVE    (8),
        .V_FP        (2),
        .V_SYNC      (1),
        .V_BP        (2),
        .WIN_STA     (2),
        .WIN_END     (6),
        .HS_POL      (1'b1),
        .VS_POL      (1'b1),
        .SCALE_SHIFT (0)
    ) u_dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_b)
    );

    cfg_t cfg_a, cfg_b;
    pos_t pos_a, pos_b;
    exp_t q_a[$];
    exp_t q_b[$];
    int   vectors = 0;
    int   errors  = 0;

    // dut_b probes over the first three frames after reset (3 * 13 * 800 strobes).
    localparam int B_WINDOW = 31200;
    int n_stb_b, an_cnt, an_bad, se_cnt, se_bad, vs_cnt, vs_first, x_max_b;

    function automatic pos_t step(cfg_t c, pos_t p, bit r, bit s);
        pos_t n = p;
        int ht = c.ha + c.hf + c.hsw + c.hb;
        int vt = c.va + c.vf + c.vsw + c.vb;
        if (r) begin
            n.h = 0; n.v = 0; n.frame = 0;
        end else if (s) begin
            if (p.h == ht - 1) begin
                n.h = 0;
                if (p.v == vt - 1) begin
                    n.v = 0;
                    n.frame = (p.frame + 1) % 256;
                end else begin
                    n.v = p.v + 1;
                end
            end else begin
                n.h = p.h + 1;
            end
        end
        return n;
    endfunction

    function automatic exp_t expect_of(cfg_t c, pos_t p);
        exp_t e;
        int ht = c.ha + c.hf + c.hsw + c.hb;
        int vt = c.va + c.vf + c.vsw + c.vb;
        e.hs         = (p.h >= c.ha + c.hf && p.h < c.ha + c.hf + c.hsw) ? c.hp : !c.hp;
        e.vs         = (p.v >= c.va + c.vf && p.v < c.va + c.vf + c.vsw) ? c.vp : !c.vp;
        e.blanking   = (p.h >= c.ha) || (p.v >= c.va);
        e.active     = (p.h < c.ha) && (p.v >= c.ws) && (p.v < c.we);
        e.line_start = (p.h == 0);
        e.animate    = (p.v == c.we - 1) && (p.h == ht - 1);
        e.screenend  = (p.v == vt - 1) && (p.h == ht - 1);
        e.x          = (p.h < c.ha) ? 32'(p.h >> c.sh) : 32'd0;
        if (p.v < c.ws)       e.y = 32'd0;
        else if (p.v >= c.we) e.y = 32'((c.we - c.ws - 1) >> c.sh);
        else                  e.y = 32'((p.v - c.ws) >> c.sh);
        e.frame      = 32'(p.frame);
        return e;
    endfunction

    function automatic exp_t obs(input logic hs, vs, act, blk, ls, an, se,
                                 input logic [31:0] x, y, fr);
        exp_t o;
        o.hs = hs; o.vs = vs; o.active = act; o.blanking = blk;
        o.line_start = ls; o.animate = an; o.screenend = se;
        o.x = x; o.y = y; o.frame = fr;
        return o;
    endfunction

    function automatic exp_t obs_a();
        return obs(bus_a.o_hs, bus_a.o_vs, bus_a.o_active, bus_a.o_blanking,
                   bus_a.o_line_start, bus_a.o_animate, bus_a.o_screenend,
                   32'(bus_a.o_x), 32'(bus_a.o_y), 32'(bus_a.o_frame));
    endfunction

    function automatic exp_t obs_b();
        return obs(bus_b.o_hs, bus_b.o_vs, bus_b.o_active, bus_b.o_blanking,
                   bus_b.o_line_start, bus_b.o_animate, bus_b.o_screenend,
                   32'(bus_b.o_x), 32'(bus_b.o_y), 32'(bus_b.o_frame));
    endfunction

    task automatic print_fail(input string name, input exp_t o, input exp_t e);
        $display("FAIL %s: got hs=%b vs=%b act=%b blk=%b ls=%b an=%b se=%b x=%0d y=%0d fr=%0d | want hs=%b vs=%b act=%b blk=%b ls=%b an=%b se=%b x=%0d y=%0d fr=%0d",
                 name, o.hs, o.vs, o.active, o.blanking, o.line_start, o.animate, o.screenend,
                 o.x, o.y, o.frame, e.hs, e.vs, e.active, e.blanking, e.line_start,
                 e.animate, e.screenend, e.x, e.y, e.frame);
    endtask

    // Scoreboard: one prediction per DUT per edge, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e, o;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            o = obs_a();
            vectors++;
            if (o !== e) begin
                errors++;
                print_fail($sformatf("scoreboard_a v=%0d h=%0d", pos_a.v, pos_a.h), o, e);
            end
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            o = obs_b();
            vectors++;
            if (o !== e) begin
                errors++;
                print_fail($sformatf("scoreboard_b v=%0d h=%0d", pos_b.v, pos_b.h), o, e);
            end
        end
    end

    // Drive one clock of stimulus, queue predictions, return 1 time unit
    // after the edge. Before the edge it also probes dut_b's pulse outputs
    // against the model position they belong to.
    task automatic tick(input bit r, input bit s);
        rst = r;
        stb = s;
        if (r) begin
            n_stb_b = 0;
        end else begin
            if (32'(bus_b.o_x) > x_max_b) x_max_b = 32'(bus_b.o_x);
            if (s && n_stb_b < B_WINDOW) begin
                if (bus_b.o_animate === 1'b1) begin
                    an_cnt++;
                    if (!(pos_b.v == 5 && pos_b.h == 799)) an_bad++;
                end
                if (bus_b.o_screenend === 1'b1) begin
                    se_cnt++;
                    if (!(pos_b.v == 12 && pos_b.h == 799)) se_bad++;
                end
                if (n_stb_b < 10400 && bus_b.o_vs === 1'b1) begin
                    if (vs_cnt == 0) vs_first = n_stb_b;
                    vs_cnt++;
                end
                n_stb_b++;
            end
        end
        pos_a = step(cfg_a, pos_a, r, s);
        pos_b = step(cfg_b, pos_b, r, s);
        q_a.push_back(expect_of(cfg_a, pos_a));
        q_b.push_back(expect_of(cfg_b, pos_b));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] got[13];
        logic [31:0] want[13];
        string       nm[13];
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        nm[0]  = "reset_a_x";          got[0]  = 32'(bus_a.o_x);          want[0]  = 0;
        nm[1]  = "reset_a_y";          got[1]  = 32'(bus_a.o_y);          want[1]  = 0;
        nm[2]  = "reset_a_blanking";   got[2]  = 32'(bus_a.o_blanking);   want[2]  = 0;
        nm[3]  = "reset_a_active";     got[3]  = 32'(bus_a.o_active);     want[3]  = 0;
        nm[4]  = "reset_a_line_start"; got[4]  = 32'(bus_a.o_line_start); want[4]  = 1;
        nm[5]  = "reset_a_hs";         got[5]  = 32'(bus_a.o_hs);         want[5]  = 1;
        nm[6]  = "reset_a_vs";         got[6]  = 32'(bus_a.o_vs);         want[6]  = 1;
        nm[7]  = "reset_a_frame";      got[7]  = 32'(bus_a.o_frame);      want[7]  = 0;
        nm[8]  = "reset_a_animate";    got[8]  = 32'(bus_a.o_animate);    want[8]  = 0;
        nm[9]  = "reset_a_screenend";  got[9]  = 32'(bus_a.o_screenend);  want[9]  = 0;
        nm[10] = "reset_b_hs";         got[10] = 32'(bus_b.o_hs);         want[10] = 0;
        nm[11] = "reset_b_vs";         got[11] = 32'(bus_b.o_vs);         want[11] = 0;
        nm[12] = "reset_b_y";          got[12] = 32'(bus_b.o_y);          want[12] = 0;
        for (int i = 0; i < 13; i++) begin
            vectors++;
            if (got[i] !== want[i]) begin
                errors++;
                $display("FAIL %s: got %0d want %0d", nm[i], got[i], want[i]);
            end
        end
    endtask

    // Strobe every 4th clock for two lines; measure the hsync pulse on line 0.
    task automatic test_hsync_slow();
        int a_first = -1, a_cnt = 0, b_first = -1, b_cnt = 0;
        for (int i = 0; i < 6400; i++) begin
            tick(1'b0, (i % 4) == 3);
            if ((i % 4) == 3 && pos_a.v == 0) begin
                if (bus_a.o_hs === 1'b0) begin
                    if (a_first < 0) a_first = pos_a.h;
                    a_cnt++;
                end
                if (bus_b.o_hs === 1'b1) begin
                    if (b_first < 0) b_first = pos_b.h;
                    b_cnt++;
                end
            end
        end
        vectors++;
        if (a_first !== 656) begin errors++; $display("FAIL hs_a_start: got h=%0d want h=656", a_first); end
        vectors++;
        if (a_cnt !== 96) begin errors++; $display("FAIL hs_a_width: got %0d want 96", a_cnt); end
        vectors++;
        if (b_first !== 656) begin errors++; $display("FAIL hs_b_start: got h=%0d want h=656", b_first); end
        vectors++;
        if (b_cnt !== 96) begin errors++; $display("FAIL hs_b_width: got %0d want 96", b_cnt); end
        vectors++;
        if (pos_a.v !== 2 || bus_a.o_line_start !== 1'b1) begin
            errors++;
            $display("FAIL two_lines_wrap: got line_start=%b want 1 at v=2", bus_a.o_line_start);
        end
    endtask

    // Full-rate strobes up to line 60 of dut_a, then walk the visible part.
    task automatic test_window();
        int guard = 0, run = 0, bad = 0;
        logic [31:0] prev_x;
        exp_t o;
        while (!(pos_a.v == 60 && pos_a.h == 0) && guard < 60000) begin
            tick(1'b0, 1'b1);
            guard++;
        end
        vectors++;
        if (guard >= 60000) begin
            errors++;
            $display("FAIL reach_line60: got v=%0d h=%0d want v=60 h=0", pos_a.v, pos_a.h);
        end
        prev_x = 32'hFFFF_FFFF;
        for (int i = 0; i < 640; i++) begin
            if (i > 0) tick(1'b0, 1'b1);
            o = obs_a();
            vectors++;
            if (o.active !== 1'b1 || o.y !== 32'd0 || o.x !== 32'(i / 2)) begin
                errors++;
                $display("FAIL window_line60 h=%0d: got act=%b y=%0d x=%0d want act=1 y=0 x=%0d",
                         i, o.active, o.y, o.x, i / 2);
            end
            if (o.x === prev_x) begin
                run++;
            end else begin
                if (i > 0 && run != 2) bad++;
                run = 1;
            end
            prev_x = o.x;
        end
        vectors++;
        if (prev_x !== 32'd319 || run != 2 || bad != 0) begin
            errors++;
            $display("FAIL x_hold: got last_x=%0d last_run=%0d bad_runs=%0d want 319 2 0", prev_x, run, bad);
        end
    endtask

    // dut_b pulse and coordinate probes collected by tick() over three frames.
    task automatic test_frames();
        vectors++;
        if (an_cnt !== 3 || an_bad !== 0) begin
            errors++;
            $display("FAIL animate_count: got %0d pulses (%0d misplaced) want 3 (0)", an_cnt, an_bad);
        end
        vectors++;
        if (se_cnt !== 3 || se_bad !== 0) begin
            errors++;
            $display("FAIL screenend_count: got %0d pulses (%0d misplaced) want 3 (0)", se_cnt, se_bad);
        end
        vectors++;
        if (vs_cnt !== 800 || vs_first !== 8000) begin
            errors++;
            $display("FAIL vs_b_pulse: got %0d strobes from %0d want 800 from 8000", vs_cnt, vs_first);
        end
        vectors++;
        if (x_max_b !== 639) begin
            errors++;
            $display("FAIL x_b_max: got %0d want 639", x_max_b);
        end
    endtask

    // Strobe low for 50 clocks: nothing may move.
    task automatic test_stall();
        exp_t ea = expect_of(cfg_a, pos_a);
        exp_t eb = expect_of(cfg_b, pos_b);
        exp_t o;
        for (int i = 0; i < 50; i++) begin
            tick(1'b0, 1'b0);
            o = obs_a();
            vectors++;
            if (o !== ea) begin errors++; print_fail($sformatf("stall_a cyc=%0d", i), o, ea); end
            o = obs_b();
            vectors++;
            if (o !== eb) begin errors++; print_fail($sformatf("stall_b cyc=%0d", i), o, eb); end
        end
    endtask

    // Reset together with a strobe in the middle of a frame.
    task automatic test_midframe_reset();
        int guard = 0;
        exp_t o, e;
        tick(1'b0, 1'b1);
        while (pos_a.h != 123 && guard < 1000) begin
            tick(1'b0, 1'b1);
            guard++;
        end
        vectors++;
        if (guard >= 1000 || pos_a.v != 61) begin
            errors++;
            $display("FAIL reach_mid: got v=%0d h=%0d want v=61 h=123", pos_a.v, pos_a.h);
        end
        tick(1'b1, 1'b1);
        e = '0;
        e.hs = 1'b1; e.vs = 1'b1; e.line_start = 1'b1;
        o = obs_a();
        vectors++;
        if (o !== e) begin errors++; print_fail("midframe_reset_a", o, e); end
        vectors++;
        if (bus_b.o_frame !== 8'd0 || bus_b.o_line_start !== 1'b1) begin
            errors++;
            $display("FAIL midframe_reset_b: got frame=%0d ls=%b want 0 1", bus_b.o_frame, bus_b.o_line_start);
        end
        tick(1'b0, 1'b1);
        vectors++;
        if (bus_a.o_line_start !== 1'b0 || bus_a.o_x !== 10'd0) begin
            errors++;
            $display("FAIL restart_h1: got ls=%b x=%0d want 0 0", bus_a.o_line_start, bus_a.o_x);
        end
        tick(1'b0, 1'b1);
        vectors++;
        if (bus_a.o_x !== 10'd1) begin
            errors++;
            $display("FAIL restart_h2: got x=%0d want 1", bus_a.o_x);
        end
    endtask

    initial begin
        cfg_a = '{ha:640, hf:16, hsw:96, hb:48, va:480, vf:10, vsw:2, vb:33,
                  ws:60, we:420, sh:1, hp:1'b0, vp:1'b0};
        cfg_b = '{ha:640, hf:16, hsw:96, hb:48, va:8, vf:2, vsw:1, vb:2,
                  ws:2, we:6, sh:0, hp:1'b1, vp:1'b1};
        pos_a = '{h:0, v:0, frame:0};
        pos_b = '{h:0, v:0, frame:0};
        n_stb_b = 0; an_cnt = 0; an_bad = 0; se_cnt = 0; se_bad = 0;
        vs_cnt = 0; vs_first = -1; x_max_b = 0;

        test_reset();
        test_hsync_slow();
        test_window();
        test_frames();
        test_stall();
        test_midframe_reset();

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
